// File: rtl/wbs_pkg.sv
// Shared types and defaults for the weighted burst scheduler.
package wbs_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, REFILL} wbs_state_t;

  localparam int unsigned DEF_INIT_WEIGHT = 3;
  localparam int unsigned STATS_W         = 16;

endpackage

// File: rtl/wbs_rr_pick.sv
// Round-robin picker: first set bit of eligible at or above ptr, wrapping.
module wbs_rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   window;
  int                   sum;

  always_comb begin
    doubled = {eligible, eligible};
    // window[j] corresponds to requester (ptr + j) mod NUM_REQ
    window  = doubled[ptr +: NUM_REQ];
    found   = |eligible;
    idx     = '0;
    sum     = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (window[j]) begin
        sum = int'(ptr) + j;
        if (sum >= int'(NUM_REQ)) begin
          sum = sum - int'(NUM_REQ);
        end
        idx = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/weighted_burst_scheduler.sv
// Credit-weighted round-robin burst arbiter for one shared resource.
// Defining WBS_STATS_EN adds a saturating refill_cnt output.
module weighted_burst_scheduler
  import wbs_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned WGT_W       = 4,
  parameter  int unsigned INIT_WEIGHT = DEF_INIT_WEIGHT,
  parameter  int unsigned MAX_HOLD    = 8,
  localparam int unsigned IDX_W       = $clog2(NUM_REQ),
  localparam int unsigned HOLD_W      = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               busy,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [WGT_W-1:0]   cfg_wdata
`ifdef WBS_STATS_EN
  ,
  output logic [STATS_W-1:0] refill_cnt
`endif
);

  wbs_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [WGT_W-1:0]   weight_cfg [NUM_REQ];
  logic [WGT_W-1:0]   credit     [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic               hold_done;
  logic               refill_enter;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      eligible[i] = req[i] && (credit[i] != '0);
    end
  end

  wbs_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign ptr_next     = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
  assign hold_done    = (hold_cnt == HOLD_W'(MAX_HOLD)) || !req[gnt_id];
  assign refill_enter = (state == IDLE) && !pick_found && (req != '0);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        weight_cfg[i] <= WGT_W'(INIT_WEIGHT);
        credit[i]     <= WGT_W'(INIT_WEIGHT);
      end
    end else begin
      if (cfg_we && (32'(cfg_idx) < NUM_REQ)) begin
        weight_cfg[cfg_idx] <= cfg_wdata;
      end
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            gnt              <= NUM_REQ'(1) << pick_idx;
            gnt_id           <= pick_idx;
            credit[pick_idx] <= credit[pick_idx] - WGT_W'(1);
            ptr              <= ptr_next;
            hold_cnt         <= HOLD_W'(1);
            state            <= GRANT;
          end else if (refill_enter) begin
            state <= REFILL;
          end
        end
        GRANT: begin
          // Dropping to IDLE forces one dead cycle before the next grant
          if (hold_done) begin
            gnt      <= '0;
            gnt_id   <= '0;
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        REFILL: begin
          // Reads weight_cfg before any same-edge config write lands
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            credit[i] <= weight_cfg[i];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WBS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      refill_cnt <= '0;
    end else if (refill_enter && (refill_cnt != '1)) begin
      refill_cnt <= refill_cnt + STATS_W'(1);
    end
  end
`endif

endmodule
